// File: rtl/switch_debouncer.sv
// Per-bit switch conditioner: 2-FF synchroniser into clk_2, stability-counter
// debounce, and registered rise/fall/any-change pulses aligned with sw_clean.
module switch_debouncer #(
    parameter int unsigned NBITS           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             clk_2,
    input  logic             reset,
    input  logic [NBITS-1:0] sw_raw,
    output logic [NBITS-1:0] sw_clean,
    output logic [NBITS-1:0] sw_rise,
    output logic [NBITS-1:0] sw_fall,
    output logic             sw_any_change
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NBITS-1:0] s1;
    logic [NBITS-1:0] s2;
    logic [CNT_W-1:0] cnt     [NBITS];
    logic [CNT_W-1:0] cnt_nxt [NBITS];
    logic [NBITS-1:0] clean_nxt;
    logic [NBITS-1:0] rise_nxt;
    logic [NBITS-1:0] fall_nxt;

    // A mismatch must persist DEBOUNCE_CYCLES evaluations; any agreement clears the count.
    always_comb begin
        clean_nxt = sw_clean;
        rise_nxt  = '0;
        fall_nxt  = '0;
        for (int unsigned i = 0; i < NBITS; i++) begin
            cnt_nxt[i] = '0;
            if (s2[i] != sw_clean[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    clean_nxt[i] = s2[i];
                    rise_nxt[i]  = s2[i];
                    fall_nxt[i]  = ~s2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            s1            <= '0;
            s2            <= '0;
            sw_clean      <= '0;
            sw_rise       <= '0;
            sw_fall       <= '0;
            sw_any_change <= 1'b0;
            for (int unsigned i = 0; i < NBITS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1            <= sw_raw;
            s2            <= s1;
            sw_clean      <= clean_nxt;
            sw_rise       <= rise_nxt;
            sw_fall       <= fall_nxt;
            sw_any_change <= |(rise_nxt | fall_nxt);
            for (int unsigned i = 0; i < NBITS; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: table of hold-and-check rows for the default
// instance, plus a latency sweep on DEBOUNCE_CYCLES=1 and =10 instances.
module tb_switch_debouncer;

    logic       clk_2 = 1'b0;
    always #5 clk_2 = ~clk_2;

    logic       reset   = 1'b1;
    logic [7:0] sw_raw  = 8'hFF;
    logic       reset_p = 1'b1;
    logic [7:0] raw_p   = 8'h00;

    logic [7:0] sw_clean, sw_rise, sw_fall;
    logic       sw_any_change;
    logic [7:0] c1, r1, f1;
    logic       a1;
    logic [7:0] c10, r10, f10;
    logic       a10;

    switch_debouncer #(.NBITS(8), .DEBOUNCE_CYCLES(4)) dut (
        .clk_2(clk_2), .reset(reset), .sw_raw(sw_raw),
        .sw_clean(sw_clean), .sw_rise(sw_rise), .sw_fall(sw_fall),
        .sw_any_change(sw_any_change)
    );

    switch_debouncer #(.NBITS(8), .DEBOUNCE_CYCLES(1)) dut_d1 (
        .clk_2(clk_2), .reset(reset_p), .sw_raw(raw_p),
        .sw_clean(c1), .sw_rise(r1), .sw_fall(f1), .sw_any_change(a1)
    );

    switch_debouncer #(.NBITS(8), .DEBOUNCE_CYCLES(10)) dut_d10 (
        .clk_2(clk_2), .reset(reset_p), .sw_raw(raw_p),
        .sw_clean(c10), .sw_rise(r10), .sw_fall(f10), .sw_any_change(a10)
    );

    typedef struct {
        string       name;
        bit          rst;
        logic [7:0]  raw;
        int unsigned n;      // edges to run (table) or edge index (sweep)
        int unsigned sel;    // sweep: 0 = DEBOUNCE_CYCLES=1, 1 = DEBOUNCE_CYCLES=10
        logic [7:0]  clean;
        logic [7:0]  rise;
        logic [7:0]  fall;
        logic        any;
    } vec_t;

    vec_t        vecs[$];
    vec_t        exp_q[$];
    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    function automatic vec_t mk(input string name, input bit rst, input logic [7:0] raw,
                                input int unsigned n, input logic [7:0] clean,
                                input logic [7:0] rise, input logic [7:0] fall, input logic any);
        vec_t v;
        v.name = name; v.rst = rst; v.raw = raw; v.n = n; v.sel = 0;
        v.clean = clean; v.rise = rise; v.fall = fall; v.any = any;
        return v;
    endfunction

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_2);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        vecs.push_back(mk("reset",       1, 8'hFF, 2, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(mk("rel_wait",    0, 8'hFF, 5, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(mk("rel_accept",  0, 8'hFF, 1, 8'hFF, 8'hFF, 8'h00, 1));
        vecs.push_back(mk("rel_hold",    0, 8'hFF, 1, 8'hFF, 8'h00, 8'h00, 0));
        vecs.push_back(mk("fall_wait",   0, 8'h00, 5, 8'hFF, 8'h00, 8'h00, 0));
        vecs.push_back(mk("fall_accept", 0, 8'h00, 1, 8'h00, 8'h00, 8'hFF, 1));
        vecs.push_back(mk("fall_hold",   0, 8'h00, 1, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(mk("step_wait",   0, 8'h04, 5, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(mk("step_accept", 0, 8'h04, 1, 8'h04, 8'h04, 8'h00, 1));
        vecs.push_back(mk("step_hold",   0, 8'h04, 1, 8'h04, 8'h00, 8'h00, 0));
        for (int r = 0; r < 5; r++) begin
            vecs.push_back(mk("bounce_hi", 0, 8'h05, 3, 8'h04, 8'h00, 8'h00, 0));
            vecs.push_back(mk("bounce_lo", 0, 8'h04, 3, 8'h04, 8'h00, 8'h00, 0));
        end
        vecs.push_back(mk("b0_wait",     0, 8'h05, 5, 8'h04, 8'h00, 8'h00, 0));
        vecs.push_back(mk("b0_accept",   0, 8'h05, 1, 8'h05, 8'h01, 8'h00, 1));
        vecs.push_back(mk("b0_hold",     0, 8'h05, 1, 8'h05, 8'h00, 8'h00, 0));
        vecs.push_back(mk("to0f_wait",   0, 8'h0F, 5, 8'h05, 8'h00, 8'h00, 0));
        vecs.push_back(mk("to0f_accept", 0, 8'h0F, 1, 8'h0F, 8'h0A, 8'h00, 1));
        vecs.push_back(mk("to0f_hold",   0, 8'h0F, 1, 8'h0F, 8'h00, 8'h00, 0));
        vecs.push_back(mk("swap_wait",   0, 8'hF0, 5, 8'h0F, 8'h00, 8'h00, 0));
        vecs.push_back(mk("swap_accept", 0, 8'hF0, 1, 8'hF0, 8'hF0, 8'h0F, 1));
        vecs.push_back(mk("swap_hold",   0, 8'hF0, 1, 8'hF0, 8'h00, 8'h00, 0));
        vecs.push_back(mk("clr_wait",    0, 8'h00, 5, 8'hF0, 8'h00, 8'h00, 0));
        vecs.push_back(mk("clr_accept",  0, 8'h00, 1, 8'h00, 8'h00, 8'hF0, 1));
        vecs.push_back(mk("clr_hold",    0, 8'h00, 1, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(mk("mid_count",   0, 8'h80, 3, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(mk("mid_reset",   1, 8'h80, 1, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(mk("b7_wait",     0, 8'h80, 5, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(mk("b7_accept",   0, 8'h80, 1, 8'h80, 8'h80, 8'h00, 1));
        vecs.push_back(mk("b7_hold",     0, 8'h80, 1, 8'h80, 8'h00, 8'h00, 0));

        foreach (vecs[k]) begin
            vec_t       v;
            vec_t       e;
            logic [7:0] quiet;
            v      = vecs[k];
            reset  = v.rst;
            sw_raw = v.raw;
            exp_q.push_back(v);
            quiet  = 8'h00;
            for (int unsigned c = 0; c < v.n; c++) begin
                tick();
                if (c + 1 < v.n) quiet |= sw_rise | sw_fall | {7'b0, sw_any_change};
            end
            e = exp_q.pop_front();
            if (e.n > 1) check8({e.name, " quiet"}, quiet, 8'h00);
            check8({e.name, " clean"}, sw_clean, e.clean);
            check8({e.name, " rise"},  sw_rise,  e.rise);
            check8({e.name, " fall"},  sw_fall,  e.fall);
            check8({e.name, " any"},   {7'b0, sw_any_change}, {7'b0, e.any});
        end

        // Latency sweep: step on bit 1 after reset release.
        reset_p = 1'b1;
        raw_p   = 8'h00;
        tick();
        tick();
        reset_p = 1'b0;
        raw_p   = 8'h02;
        begin
            vec_t s;
            s = mk("d1_before",  0, 8'h02,  2, 8'h00, 8'h00, 8'h00, 0); s.sel = 0; exp_q.push_back(s);
            s = mk("d1_accept",  0, 8'h02,  3, 8'h02, 8'h02, 8'h00, 1); s.sel = 0; exp_q.push_back(s);
            s = mk("d1_hold",    0, 8'h02,  4, 8'h02, 8'h00, 8'h00, 0); s.sel = 0; exp_q.push_back(s);
            s = mk("d10_before", 0, 8'h02, 11, 8'h00, 8'h00, 8'h00, 0); s.sel = 1; exp_q.push_back(s);
            s = mk("d10_accept", 0, 8'h02, 12, 8'h02, 8'h02, 8'h00, 1); s.sel = 1; exp_q.push_back(s);
            s = mk("d10_hold",   0, 8'h02, 13, 8'h02, 8'h00, 8'h00, 0); s.sel = 1; exp_q.push_back(s);
        end
        for (int unsigned edge_n = 1; edge_n <= 13; edge_n++) begin
            tick();
            while (exp_q.size() > 0 && exp_q[0].n == edge_n) begin
                vec_t e;
                e = exp_q.pop_front();
                if (e.sel == 0) begin
                    check8({e.name, " clean"}, c1, e.clean);
                    check8({e.name, " rise"},  r1, e.rise);
                    check8({e.name, " fall"},  f1, e.fall);
                    check8({e.name, " any"},   {7'b0, a1}, {7'b0, e.any});
                end else begin
                    check8({e.name, " clean"}, c10, e.clean);
                    check8({e.name, " rise"},  r10, e.rise);
                    check8({e.name, " fall"},  f10, e.fall);
                    check8({e.name, " any"},   {7'b0, a10}, {7'b0, e.any});
                end
            end
        end
        check8("sweep_drained", 8'(exp_q.size()), 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
